gpio_input_conditioner: RTL and testbench
=========================================

# gpio_input_conditioner

Input conditioning stage directly upstream of `gpio_controller`. It takes raw asynchronous pad levels, synchronizes them into the `sys_clk` domain and optionally debounces each pin. It drives the controller's `gpio_in_data` bus and also produces single-cycle rise/fall event pulses for later interrupt logic. Per-pin debounce enables and timing come from controller configuration registers.

## Interface

Parameters:
- `NUM_GPIO`, default 256: number of pins; matches the controller's GPIO bus width.
- `SYNC_STAGES`, default 2: synchronizer depth; legal range ≥2.
- `DEBOUNCE_W`, default 4: width of the per-pin debounce counter and of the threshold.
- `DIV_W`, default 16: width of the sample prescaler.

Ports:
- `sys_clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `gpio_pad_in`  in  NUM_GPIO  raw pad levels, asynchronous to `sys_clk`.
- `debounce_en`  in  NUM_GPIO  per-pin debounce enable.
- `debounce_threshold`  in  DEBOUNCE_W  number of consecutive mismatching sample ticks before a pin flips; 0 is treated as 1.
- `sample_div`  in  DIV_W  prescaler divisor; one tick every `sample_div+1` cycles.
- `gpio_in_data`  out  NUM_GPIO  conditioned levels, fed to the controller.
- `gpio_rise`  out  NUM_GPIO  one-cycle pulse when a conditioned level goes 0→1.
- `gpio_fall`  out  NUM_GPIO  one-cycle pulse when a conditioned level goes 1→0.

## Operation

- **Synchronizer:** a `SYNC_STAGES`-deep flop chain per pin, reset to 0. All downstream logic uses only the final stage, `sync[i]`.
- **Prescaler:** a `DIV_W`-bit counter.
  - When `cnt >= sample_div`, assert `tick` and clear `cnt`; otherwise increment it.
  - `sample_div=0` gives a tick every cycle.
  - Using `>=` means that lowering `sample_div` mid-count takes effect within one cycle.
- **Per-pin state:** conditioned level `lvl[i]` and debounce counter `dcnt[i]`.
- **Debounce disabled** (`debounce_en[i]=0`): `lvl[i] <= sync[i]` every cycle and `dcnt[i] <= 0`. The prescaler is ignored.
- **Debounce enabled**, on a tick:
  - If `sync[i]==lvl[i]`, clear `dcnt[i]`.
  - If they differ and `dcnt[i] >= T_eff-1`, where `T_eff = max(debounce_threshold,1)`: set `lvl[i] <= sync[i]` and `dcnt[i] <= 0`.
  - Otherwise increment `dcnt[i]`.
  - With no tick, `lvl[i]` and `dcnt[i]` hold.
- **Glitch rejection:** any tick that sees `sync==lvl` clears the count, so a glitch shorter than `T_eff` consecutive ticks never reaches `gpio_in_data`.
- **Enable toggling:** toggling `debounce_en[i]` clears `dcnt[i]`, because the disabled path forces it to 0. `lvl[i]` is never forced.
- **Threshold change mid-count:** `>=` comparison, so a pending count at or above the new threshold flips on the next mismatching tick.
- **Edges:** `gpio_rise[i]` is registered as `lvl_next[i] & ~lvl[i]`; `gpio_fall[i]` is the complement case. Each is high for exactly the first cycle in which `gpio_in_data` shows the new level.
- **Outputs:** `gpio_in_data = lvl`, driven directly from flops.

## Timing

- **Reset:** all synchronizer flops, `lvl`, `dcnt`, the prescaler, `gpio_in_data`, `gpio_rise` and `gpio_fall` are 0. Deassertion does not generate edge pulses for pads that are already high; the first rise appears after the normal latency.
- **Latency, debounce off:** `gpio_in_data` changes `SYNC_STAGES+1` edges after the first edge that samples the new pad level. That is 3 cycles at defaults.
- **Latency, debounce on, `sample_div=0`:** `SYNC_STAGES+T_eff` edges.
- **Latency, general case:** at most `SYNC_STAGES + T_eff*(sample_div+1)` edges.
- **Reset mid-debounce:** any pending count is discarded and the level returns to 0 immediately. Because reset is asynchronous, outputs clear without a clock.
- **Counter overflow:** `dcnt` cannot exceed `T_eff-1`, because the flip clears it. There is no wrap.

## Configuration

- `GPIO_IN_EDGE_DETECT_EN`:
  - Defined: `gpio_rise`/`gpio_fall` are generated as described above.
  - Undefined: both ports are tied to constant 0 and no edge flops are instantiated.
  - `gpio_in_data` behaviour is identical in both builds.

## Structure

- **Shared package `gpio_pkg`:** the `NUM_GPIO` default constant, shared with `gpio_controller`, and the `DEBOUNCE_W` and `DIV_W` default constants.
- **Sub-module `gpio_debounce_cell`:** one pin's synchronizer, `lvl`/`dcnt` logic and edge flops. It is instantiated `NUM_GPIO` times in a generate loop.
- **Top level:** holds the single shared prescaler and its tick fan-out.

## Test plan

- **Reset:** pads all 1 during reset, then release → all outputs 0 during reset. `gpio_in_data` goes all-ones 3 cycles after release; with edge detect built in, `gpio_rise` is all-ones for exactly one cycle.
- **Debounce off:** `debounce_en=0`, pad[5] 0→1 → `gpio_in_data[5]=1` after edge 3, with `gpio_rise[5]` pulsed in that same cycle.
- **Debounce timing:** `debounce_en[7]=1`, `threshold=4`, `sample_div=0`; pad[7] rises and stays high → `gpio_in_data[7]` rises after edge 6.
- **Glitch rejection:** same setup as above; pad[7] high for 3 cycles then low → `gpio_in_data[7]` stays 0 and no `gpio_rise`.
- **Prescaler:** `sample_div=9`, `threshold=2`; pad[0] steps high → flip occurs within 2+2×10 cycles and no earlier than 2+10 cycles. Also set `threshold=0` → behaves as threshold 1.
- **Reset mid-operation:** assert `rst_n` low while `dcnt[7]=2` and `gpio_in_data` is nonzero → all outputs clear asynchronously. After release, a stable pad needs the full threshold again.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared GPIO package: default widths shared between gpio_controller and the input conditioner.
package gpio_pkg;

  localparam int unsigned NumGpioDefault   = 256;
  localparam int unsigned DebounceWDefault = 4;
  localparam int unsigned DivWDefault      = 16;

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Bus bundle between the pad/config side and gpio_input_conditioner.
//   master: drives gpio_pad_in, debounce_en, debounce_threshold, sample_div;
//           receives gpio_in_data, gpio_rise, gpio_fall.
//   slave : the conditioner (mirror of master).
interface gpio_input_conditioner_if
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_GPIO   = NumGpioDefault,
  parameter int unsigned DEBOUNCE_W = DebounceWDefault,
  parameter int unsigned DIV_W      = DivWDefault
);

  logic [NUM_GPIO-1:0]   gpio_pad_in;
  logic [NUM_GPIO-1:0]   debounce_en;
  logic [DEBOUNCE_W-1:0] debounce_threshold;
  logic [DIV_W-1:0]      sample_div;
  logic [NUM_GPIO-1:0]   gpio_in_data;
  logic [NUM_GPIO-1:0]   gpio_rise;
  logic [NUM_GPIO-1:0]   gpio_fall;

  modport master (
    output gpio_pad_in, debounce_en, debounce_threshold, sample_div,
    input  gpio_in_data, gpio_rise, gpio_fall
  );

  modport slave (
    input  gpio_pad_in, debounce_en, debounce_threshold, sample_div,
    output gpio_in_data, gpio_rise, gpio_fall
  );

endinterface

// File: rtl/gpio_debounce_cell.sv
// One pin of the input conditioner: synchronizer chain, debounce level/counter, edge flops.
// Ports:
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   pad_i          : raw asynchronous pad level
//   en_i           : debounce enable for this pin
//   tick_i         : shared prescaler sample tick
//   thr_m1_i       : effective threshold minus one (threshold 0 already mapped to 1)
//   lvl_o          : conditioned level
//   rise_o, fall_o : one-cycle edge pulses (only when GPIO_IN_EDGE_DETECT_EN is defined)
module gpio_debounce_cell
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_W  = DebounceWDefault
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  pad_i,
  input  logic                  en_i,
  input  logic                  tick_i,
  input  logic [DEBOUNCE_W-1:0] thr_m1_i,
  output logic                  lvl_o,
  output logic                  rise_o,
  output logic                  fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  logic                   lvl_q, lvl_d;
  logic [DEBOUNCE_W-1:0]  dcnt_q, dcnt_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
    lvl_d  = lvl_q;
    dcnt_d = dcnt_q;
    if (!en_i) begin
      // Bypass: follow the synchronizer, keep the counter cleared.
      lvl_d  = sync;
      dcnt_d = '0;
    end else if (tick_i) begin
      if (sync == lvl_q) begin
        dcnt_d = '0;
      end else if (dcnt_q >= thr_m1_i) begin
        // >= so a lowered threshold takes effect on the next mismatching tick.
        lvl_d  = sync;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DEBOUNCE_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign lvl_o = lvl_q;

`ifdef GPIO_IN_EDGE_DETECT_EN
  logic rise_q, fall_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= lvl_d & ~lvl_q;
      fall_q <= ~lvl_d & lvl_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: synchronizes raw pads into sys_clk, optionally debounces each pin,
// drives gpio_in_data for gpio_controller and (optionally) rise/fall event pulses.
// Ports:
//   sys_clk : the only clock
//   rst_n   : asynchronous active-low reset
//   gpio_io : slave modport carrying pad levels, debounce config, conditioned data and edges
// Build option: define GPIO_IN_EDGE_DETECT_EN to generate gpio_rise/gpio_fall; otherwise both
// are constant 0. The interface instance must use the same NUM_GPIO/DEBOUNCE_W/DIV_W values.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_GPIO    = NumGpioDefault,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_W  = DebounceWDefault,
  parameter int unsigned DIV_W       = DivWDefault
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  gpio_input_conditioner_if.slave    gpio_io
);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  tick;
  logic [DEBOUNCE_W-1:0] thr_m1;
  logic [NUM_GPIO-1:0]   lvl_vec, rise_vec, fall_vec;

  // >= lets a lowered divisor take effect within one cycle.
  always_comb begin
    tick      = (div_cnt_q >= gpio_io.sample_div);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  // Threshold 0 behaves as 1, so the compare value is max(thr,1)-1.
  always_comb begin
    thr_m1 = '0;
    if (gpio_io.debounce_threshold != '0) begin
      thr_m1 = gpio_io.debounce_threshold - DEBOUNCE_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_pin
    gpio_debounce_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W)
    ) u_cell (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .pad_i    (gpio_io.gpio_pad_in[g]),
      .en_i     (gpio_io.debounce_en[g]),
      .tick_i   (tick),
      .thr_m1_i (thr_m1),
      .lvl_o    (lvl_vec[g]),
      .rise_o   (rise_vec[g]),
      .fall_o   (fall_vec[g])
    );
  end

  assign gpio_io.gpio_in_data = lvl_vec;
  assign gpio_io.gpio_rise    = rise_vec;
  assign gpio_io.gpio_fall    = fall_vec;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench for gpio_input_conditioner: stimulus queues expected output snapshots keyed
// by cycle; a negedge monitor pops and compares them.
module tb_gpio_input_conditioner;
  import gpio_pkg::*;

  localparam int unsigned N  = NumGpioDefault;
  localparam int unsigned DW = DebounceWDefault;
  localparam int unsigned VW = DivWDefault;
`ifdef GPIO_IN_EDGE_DETECT_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  typedef logic [N-1:0] vec_t;
  typedef struct {
    int    cyc;
    string name;
    vec_t  mask;
    vec_t  data;
    vec_t  rise;
    vec_t  fall;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  exp_t sbq[$];
  exp_t cur;

  gpio_input_conditioner_if #(.NUM_GPIO(N), .DEBOUNCE_W(DW), .DIV_W(VW)) gpio_if ();

  gpio_input_conditioner #(
    .NUM_GPIO    (N),
    .SYNC_STAGES (2),
    .DEBOUNCE_W  (DW),
    .DIV_W       (VW)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .gpio_io (gpio_if.slave)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic vec_t pin(int i);
    vec_t v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Expected edge vector: edges only exist in the edge-detect build.
  function automatic vec_t ev(vec_t v);
    return EdgeEn ? v : '0;
  endfunction

  task automatic expect_at(int at, string name, vec_t mask, vec_t data, vec_t rise, vec_t fall);
    exp_t e;
    int   pos;
    e   = '{at, name, mask, data, rise, fall};
    pos = sbq.size();
    while (pos > 0 && sbq[pos-1].cyc > at) pos--;
    sbq.insert(pos, e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  always @(negedge sys_clk) begin
    while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      cur = sbq.pop_front();
      checks++;
      if (cur.cyc != cyc) begin
        errors++;
        $display("FAIL %s stale: checked at cycle %0d, required cycle %0d", cur.name, cyc, cur.cyc);
      end else if ((gpio_if.gpio_in_data & cur.mask) !== (cur.data & cur.mask)) begin
        errors++;
        $display("FAIL %s cyc %0d gpio_in_data actual %h required %h", cur.name, cyc,
                 gpio_if.gpio_in_data & cur.mask, cur.data & cur.mask);
      end else if ((gpio_if.gpio_rise & cur.mask) !== (cur.rise & cur.mask)) begin
        errors++;
        $display("FAIL %s cyc %0d gpio_rise actual %h required %h", cur.name, cyc,
                 gpio_if.gpio_rise & cur.mask, cur.rise & cur.mask);
      end else if ((gpio_if.gpio_fall & cur.mask) !== (cur.fall & cur.mask)) begin
        errors++;
        $display("FAIL %s cyc %0d gpio_fall actual %h required %h", cur.name, cyc,
                 gpio_if.gpio_fall & cur.mask, cur.fall & cur.mask);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    vec_t m;
    vec_t m0;
    vec_t mr;
    gpio_if.gpio_pad_in        = '1;
    gpio_if.debounce_en        = '0;
    gpio_if.debounce_threshold = '0;
    gpio_if.sample_div         = '0;
    rst_n                      = 1'b0;

    // Reset with pads high, then release: no edge on release, all-ones after 3 edges.
    step(3);
    expect_at(cyc, "reset_state", '1, '0, '0, '0);
    step(1);
    rst_n = 1'b1;
    c     = cyc;
    expect_at(c,     "rst_release", '1, '0, '0, '0);
    expect_at(c + 2, "rst_lat2",    '1, '0, '0, '0);
    expect_at(c + 3, "rst_rise",    '1, '1, ev('1), '0);
    expect_at(c + 4, "rst_pulse1",  '1, '1, '0, '0);
    step(6);
    gpio_if.gpio_pad_in = '0;
    c = cyc;
    expect_at(c + 3, "all_fall",   '1, '0, '0, ev('1));
    expect_at(c + 4, "all_fall1",  '1, '0, '0, '0);
    step(6);

    // Debounce off, pin 5.
    m = pin(5);
    gpio_if.gpio_pad_in[5] = 1'b1;
    c = cyc;
    expect_at(c + 2, "off_lat2",  m, '0, '0, '0);
    expect_at(c + 3, "off_rise",  m, m, ev(m), '0);
    expect_at(c + 4, "off_hold",  m, m, '0, '0);
    step(6);
    gpio_if.gpio_pad_in[5] = 1'b0;
    c = cyc;
    expect_at(c + 3, "off_fall",  m, '0, '0, ev(m));
    step(6);

    // Debounce on, pin 7, threshold 4, tick every cycle.
    m = pin(7);
    gpio_if.debounce_en        = m;
    gpio_if.debounce_threshold = DW'(4);
    gpio_if.sample_div         = '0;
    step(3);
    gpio_if.gpio_pad_in[7] = 1'b1;
    c = cyc;
    expect_at(c + 5, "db_lat5",  m, '0, '0, '0);
    expect_at(c + 6, "db_rise",  m, m, ev(m), '0);
    expect_at(c + 7, "db_hold",  m, m, '0, '0);
    step(10);
    gpio_if.gpio_pad_in[7] = 1'b0;
    c = cyc;
    expect_at(c + 5, "db_fall_lat5", m, m, '0, '0);
    expect_at(c + 6, "db_fall",      m, '0, '0, ev(m));
    step(10);

    // Glitch: pad[7] high for 3 cycles only.
    gpio_if.gpio_pad_in[7] = 1'b1;
    c = cyc;
    for (int k = 1; k <= 12; k++) expect_at(c + k, "glitch", m, '0, '0, '0);
    step(3);
    gpio_if.gpio_pad_in[7] = 1'b0;
    step(12);

    // Prescaler, pin 0: div 9, threshold 2. div=0 beforehand parks the counter at 0,
    // so ticks land exactly 10, 20, ... edges after div is raised.
    m0 = pin(0);
    gpio_if.debounce_en        = m0 | pin(7);
    gpio_if.debounce_threshold = DW'(2);
    gpio_if.sample_div         = '0;
    step(3);
    gpio_if.sample_div     = VW'(9);
    gpio_if.gpio_pad_in[0] = 1'b1;
    c = cyc;
    expect_at(c + 12, "pre_min_bound", m0, '0, '0, '0);
    expect_at(c + 19, "pre_before",    m0, '0, '0, '0);
    expect_at(c + 20, "pre_flip",      m0, m0, ev(m0), '0);
    step(25);
    gpio_if.sample_div = '0;
    step(3);

    // Threshold 0 acts as 1: first mismatching tick flips.
    gpio_if.debounce_threshold = '0;
    gpio_if.sample_div         = VW'(9);
    gpio_if.gpio_pad_in[0]     = 1'b0;
    c = cyc;
    expect_at(c + 9,  "thr0_before", m0, m0, '0, '0);
    expect_at(c + 10, "thr0_flip",   m0, '0, '0, ev(m0));
    step(15);

    // Reset while pin 7 is mid-count (dcnt=2) and pin 5 is high.
    mr = pin(5) | pin(7);
    gpio_if.sample_div         = '0;
    gpio_if.debounce_threshold = DW'(4);
    gpio_if.gpio_pad_in[5]     = 1'b1;
    step(5);
    gpio_if.gpio_pad_in[7] = 1'b1;
    c = cyc;
    expect_at(c + 3, "pre_reset", mr, pin(5), '0, '0);
    step(4);
    rst_n = 1'b0;
    expect_at(cyc, "async_clear", '1, '0, '0, '0);
    step(2);
    rst_n = 1'b1;
    c = cyc;
    expect_at(c + 2, "post_rst_lat2",  mr, '0, '0, '0);
    expect_at(c + 3, "post_rst_pin5",  mr, pin(5), ev(pin(5)), '0);
    expect_at(c + 5, "post_rst_hold7", mr, pin(5), '0, '0);
    expect_at(c + 6, "post_rst_pin7",  mr, mr, ev(pin(7)), '0);
    step(12);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending actual %0d required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
